bus_matrix_err_responder: RTL and testbench
===========================================

Name: bus_matrix_err_responder

Overview:
- AXI error slave that terminates transactions the address decoder/firewall rejects: decode miss (no region, no default slave) or security violation (non-secure access to a secure region).
- Instantiated once per master port, behind the decoder. It accepts the rejected AW/AR and absorbs all W beats.
- Returns protocol-correct B/R responses with an error code, so the master never hangs on an unmapped or forbidden address.

Parameters:
- ID_WIDTH, 4, width of AXI transaction ID.
- DATA_WIDTH, 32, width of R data.
- ADDR_WIDTH, 32, address width; used only when logging is enabled.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- aw_valid_i  in  1  rejected write address valid
- aw_ready_o  out  1  write address accept
- aw_id_i  in  ID_WIDTH  write ID
- aw_sec_err_i  in  1  1 = security violation, 0 = decode error
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data accept
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response accept
- b_id_o  out  ID_WIDTH  echoed AW ID
- b_resp_o  out  2  error response code
- ar_valid_i  in  1  rejected read address valid
- ar_ready_o  out  1  read address accept
- ar_id_i  in  ID_WIDTH  read ID
- ar_len_i  in  8  burst length minus 1
- ar_sec_err_i  in  1  1 = security violation, 0 = decode error
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data accept
- r_id_o  out  ID_WIDTH  echoed AR ID
- r_data_o  out  DATA_WIDTH  always zero
- r_resp_o  out  2  error response code
- r_last_o  out  1  last read beat

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - Write FSM to W_IDLE, read FSM to R_IDLE.
  - aw_ready_o=1, ar_ready_o=1.
  - w_ready_o, b_valid_o, r_valid_o, r_last_o = 0.
  - b_id_o, r_id_o, b_resp_o, r_resp_o, r_data_o = 0.
- Response codes:
  - sec_err=1 gives SLVERR, 2'b10.
  - sec_err=0 gives DECERR, 2'b11.
  - The code is captured at the address handshake.
- Write FSM:
  - W_IDLE: aw_ready_o=1. On aw_valid_i & aw_ready_o, capture ID and resp code, go to W_DATA.
  - W_DATA: aw_ready_o=0, w_ready_o=1. Every W beat is discarded. On w_valid_i & w_last_i, go to W_RESP.
  - W_RESP: w_ready_o=0, b_valid_o=1, b_id_o/b_resp_o held stable. On b_ready_i, go to W_IDLE.
  - Latency: AW handshake at cycle N gives w_ready_o at N+1. W last beat at M gives b_valid_o at M+1.
  - A single-beat write with w_valid already high completes AW to B in 3 cycles.
  - W beats presented before AW are not accepted; w_ready_o is 0 outside W_DATA. This is legal, since a slave may wait for AW.
- Read FSM:
  - R_IDLE: ar_ready_o=1. On AR handshake, capture ID, resp code and beat counter = ar_len_i, go to R_DATA.
  - R_DATA: ar_ready_o=0, r_valid_o=1, r_data_o=0, r_last_o=(counter==0).
  - Each r_valid_o & r_ready_i decrements the counter. The handshake with r_last_o=1 returns to R_IDLE.
  - AR handshake at N gives first r_valid_o at N+1. Beats follow one per cycle while r_ready_i=1.
  - ar_len_i=255 gives exactly 256 beats. The counter is 8-bit and never wraps below 0.
- Concurrency and stalls:
  - Read and write FSMs are fully independent; simultaneous AW and AR are both accepted in the same cycle.
  - Outputs are held stable while valid and not ready (AXI stability rule).
- One outstanding transaction per direction: a new AW/AR is not accepted until the prior B/last R handshake completes. No back-to-back acceptance in the response cycle; ready re-asserts the cycle after.
- Reset mid-operation: outstanding transactions are dropped; all outputs take their reset values on the next edge.

Optional Feature:
- Macro: BUS_MATRIX_ERR_LOG_EN.
- Defined adds these ports:
  - aw_addr_i, ar_addr_i, in, ADDR_WIDTH.
  - err_clear_i, in, 1.
  - err_valid_o, out, 1.
  - err_addr_o, out, ADDR_WIDTH.
  - err_is_write_o, out, 1.
  - err_is_sec_o, out, 1.
  - err_count_o, out, 16.
- Defined, behaviour:
  - Capture is sticky, first-error-wins: on the first AW/AR handshake while err_valid_o=0, latch address, direction and type, and set err_valid_o.
  - If AW and AR handshake in the same cycle, the write is captured.
  - err_count_o increments per accepted AW/AR (by 2 if both handshake together), saturating at 16'hFFFF.
  - err_clear_i clears the capture and the count; a handshake in the same cycle as clear is then captured and counted.
  - All logging outputs reset to 0.
- Undefined: none of these ports or registers exist; core behaviour is identical.

Decomposition:
- bus_matrix_pkg gains:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
  - Enums err_wr_state_t {W_IDLE, W_DATA, W_RESP} and err_rd_state_t {R_IDLE, R_DATA}.
- No sub-module; both FSMs live in one module, so the log capture sees both handshakes directly.

Test Plan:
- AW id=3, sec_err=0, then 4 W beats, last on the 4th, b_ready=1 -> 4 beats accepted, then b_valid one cycle after last, b_id=3, b_resp=2'b11.
- AR id=5, len=3, sec_err=1, r_ready=1 -> 4 R beats on consecutive cycles, r_data=0, r_resp=2'b10, r_last only on beat 4.
- AR len=255 with r_ready toggling every other cycle -> exactly 256 beats, outputs stable during stalls, r_last on beat 256.
- AW and AR in the same cycle, b_ready held 0 for 5 cycles -> read burst completes independently, b_valid holds until b_ready rises.
- rst_i pulsed mid read burst after 2 of 8 beats -> next edge r_valid=0 and ar_ready=1; a fresh AR returns a full burst.
- With BUS_MATRIX_ERR_LOG_EN: AW addr 0x4000_0000 and AR addr 0x8000_0000 in the same cycle -> err_addr=0x4000_0000, err_is_write=1, count=2; err_clear_i -> all logging outputs 0.

Source files
------------

// File: rtl/bus_matrix_pkg.sv
// Shared AXI response codes and error-responder FSM state types for the bus matrix.
package bus_matrix_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } err_wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } err_rd_state_t;

  // Security violations report SLVERR; plain decode misses report DECERR.
  function automatic logic [1:0] err_resp(input logic sec_err);
    return sec_err ? AXI_RESP_SLVERR : AXI_RESP_DECERR;
  endfunction

endpackage

// File: rtl/bus_matrix_err_responder.sv
// AXI error slave terminating decode-miss and security-violation transactions with SLVERR/DECERR.
// Optional first-error capture and error counting is enabled by defining BUS_MATRIX_ERR_LOG_EN.
module bus_matrix_err_responder
  import bus_matrix_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef BUS_MATRIX_ERR_LOG_EN
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic                  err_clear_i,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_is_write_o,
  output logic                  err_is_sec_o,
  output logic [15:0]           err_count_o,
`endif
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic                  aw_sec_err_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [7:0]            ar_len_i,
  input  logic                  ar_sec_err_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o
);

  if (ADDR_WIDTH < 1) begin : g_addr_width_check
    $error("ADDR_WIDTH must be at least 1");
  end

  err_wr_state_t         wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
  logic [1:0]            b_resp_q, b_resp_d;

  err_rd_state_t         rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [7:0]            rd_cnt_q, rd_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      b_id_q     <= '0;
      b_resp_q   <= AXI_RESP_OKAY;
      rd_state_q <= R_IDLE;
      r_id_q     <= '0;
      r_resp_q   <= AXI_RESP_OKAY;
      rd_cnt_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      b_id_q     <= b_id_d;
      b_resp_q   <= b_resp_d;
      rd_state_q <= rd_state_d;
      r_id_q     <= r_id_d;
      r_resp_q   <= r_resp_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // Write side: accept AW, swallow W beats until last, then hold B until taken.
  always_comb begin
    wr_state_d = wr_state_q;
    b_id_d     = b_id_q;
    b_resp_d   = b_resp_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          b_id_d     = aw_id_i;
          b_resp_d   = err_resp(aw_sec_err_i);
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) begin
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign b_id_o   = b_id_q;
  assign b_resp_o = b_resp_q;

  // Read side: counter holds remaining beats minus one, so zero marks the last beat.
  always_comb begin
    rd_state_d = rd_state_q;
    r_id_d     = r_id_q;
    r_resp_d   = r_resp_q;
    rd_cnt_d   = rd_cnt_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          r_id_d     = ar_id_i;
          r_resp_d   = err_resp(ar_sec_err_i);
          rd_cnt_d   = ar_len_i;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = (rd_cnt_q == 8'd0);
        if (r_ready_i) begin
          if (rd_cnt_q == 8'd0) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q - 8'd1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign r_id_o   = r_id_q;
  assign r_resp_o = r_resp_q;
  assign r_data_o = '0;

`ifdef BUS_MATRIX_ERR_LOG_EN
  logic                  aw_hs, ar_hs;
  logic                  err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  err_is_write_q, err_is_write_d;
  logic                  err_is_sec_q, err_is_sec_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [15:0]           count_base;
  logic [16:0]           count_sum;

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign ar_hs = ar_valid_i && ar_ready_o;

  // Clear is applied first so a handshake in the clear cycle is still logged.
  always_comb begin
    err_valid_d    = err_clear_i ? 1'b0 : err_valid_q;
    err_addr_d     = err_clear_i ? '0 : err_addr_q;
    err_is_write_d = err_clear_i ? 1'b0 : err_is_write_q;
    err_is_sec_d   = err_clear_i ? 1'b0 : err_is_sec_q;
    count_base     = err_clear_i ? 16'd0 : err_count_q;
    if (!err_valid_d) begin
      if (aw_hs) begin
        err_valid_d    = 1'b1;
        err_addr_d     = aw_addr_i;
        err_is_write_d = 1'b1;
        err_is_sec_d   = aw_sec_err_i;
      end else if (ar_hs) begin
        err_valid_d    = 1'b1;
        err_addr_d     = ar_addr_i;
        err_is_write_d = 1'b0;
        err_is_sec_d   = ar_sec_err_i;
      end
    end
    count_sum   = {1'b0, count_base} + 17'(aw_hs) + 17'(ar_hs);
    err_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_q    <= 1'b0;
      err_addr_q     <= '0;
      err_is_write_q <= 1'b0;
      err_is_sec_q   <= 1'b0;
      err_count_q    <= '0;
    end else begin
      err_valid_q    <= err_valid_d;
      err_addr_q     <= err_addr_d;
      err_is_write_q <= err_is_write_d;
      err_is_sec_q   <= err_is_sec_d;
      err_count_q    <= err_count_d;
    end
  end

  assign err_valid_o    = err_valid_q;
  assign err_addr_o     = err_addr_q;
  assign err_is_write_o = err_is_write_q;
  assign err_is_sec_o   = err_is_sec_q;
  assign err_count_o    = err_count_q;
`endif

endmodule

// File: tb/tb_bus_matrix_err_responder.sv
// Scoreboard bench for bus_matrix_err_responder; logging checks are built when BUS_MATRIX_ERR_LOG_EN is defined.
module tb_bus_matrix_err_responder;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              aw_valid_i = 1'b0, aw_sec_err_i = 1'b0;
  logic [ID_W-1:0]   aw_id_i = '0;
  logic              w_valid_i = 1'b0, w_last_i = 1'b0, b_ready_i = 1'b0;
  logic              ar_valid_i = 1'b0, ar_sec_err_i = 1'b0, r_ready_i = 1'b0;
  logic [ID_W-1:0]   ar_id_i = '0;
  logic [7:0]        ar_len_i = '0;
  logic              aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o;
  logic [ID_W-1:0]   b_id_o, r_id_o;
  logic [1:0]        b_resp_o, r_resp_o;
  logic [DATA_W-1:0] r_data_o;
`ifdef BUS_MATRIX_ERR_LOG_EN
  logic [ADDR_W-1:0] aw_addr_i = '0, ar_addr_i = '0;
  logic              err_clear_i = 1'b0;
  logic              err_valid_o, err_is_write_o, err_is_sec_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic [15:0]       err_count_o;
`endif

  typedef struct packed {logic [ID_W-1:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [ID_W-1:0] id; logic [1:0] resp; logic last;} r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  int     tests = 0;
  int     failures = 0;
  int     bSeen = 0;
  int     rSeen = 0;

  always #5 clk = ~clk;

  bus_matrix_err_responder #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W), .ADDR_WIDTH(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
`ifdef BUS_MATRIX_ERR_LOG_EN
    .aw_addr_i(aw_addr_i), .ar_addr_i(ar_addr_i), .err_clear_i(err_clear_i),
    .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_is_write_o(err_is_write_o),
    .err_is_sec_o(err_is_sec_o), .err_count_o(err_count_o),
`endif
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_sec_err_i(aw_sec_err_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
    .ar_sec_err_i(ar_sec_err_i), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every B/R handshake and checks stall stability.
  logic        bStallPrev = 1'b0, rStallPrev = 1'b0;
  logic [63:0] bSnap, rSnap;
  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (rst_i) begin
      bStallPrev = 1'b0;
      rStallPrev = 1'b0;
    end else begin
      if (bStallPrev) checkOutput("b_stable", 64'({b_valid_o, b_id_o, b_resp_o}), bSnap);
      if (rStallPrev) checkOutput("r_stable", 64'({r_valid_o, r_id_o, r_resp_o, r_last_o, r_data_o}), rSnap);
      if (b_valid_o && b_ready_i) begin
        if (bq.size() == 0) begin
          checkOutput("b_unexpected", 64'd1, 64'd0);
        end else begin
          be = bq.pop_front();
          checkOutput("b_beat", 64'({b_id_o, b_resp_o}), 64'({be.id, be.resp}));
        end
        bSeen++;
      end
      if (r_valid_o && r_ready_i) begin
        if (rq.size() == 0) begin
          checkOutput("r_unexpected", 64'd1, 64'd0);
        end else begin
          re = rq.pop_front();
          checkOutput("r_beat", 64'({r_id_o, r_resp_o, r_last_o, r_data_o}),
                      64'({re.id, re.resp, re.last, 32'd0}));
        end
        rSeen++;
      end
      bStallPrev = b_valid_o && !b_ready_i;
      bSnap      = 64'({b_valid_o, b_id_o, b_resp_o});
      rStallPrev = r_valid_o && !r_ready_i;
      rSnap      = 64'({r_valid_o, r_id_o, r_resp_o, r_last_o, r_data_o});
    end
  end

  task automatic applyWrite(input logic [ID_W-1:0] id, input logic sec, input int beats, input int bHold);
    int     guard;
    int     acc;
    int     target;
    b_exp_t e;
    @(posedge clk); #1;
    aw_valid_i = 1'b1; aw_id_i = id; aw_sec_err_i = sec;
    guard = 0;
    @(negedge clk);
    while (!aw_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("aw_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    aw_valid_i = 1'b0;
    e.id = id; e.resp = sec ? 2'b10 : 2'b11;
    bq.push_back(e);
    target = bSeen + 1;
    w_valid_i = 1'b1; w_last_i = (beats == 1);
    acc = 0; guard = 0;
    while (guard < 100) begin
      @(negedge clk);
      if (guard == 0) checkOutput("w_ready_latency", 64'(w_ready_o), 64'd1);
      if (w_ready_o) acc++;
      @(posedge clk); #1;
      guard++;
      if (acc == beats) break;
      w_last_i = (acc == beats - 1);
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    checkOutput("w_beats", 64'(acc), 64'(beats));
    @(negedge clk);
    checkOutput("b_valid_latency", 64'(b_valid_o), 64'd1);
    repeat (bHold) @(posedge clk);
    @(posedge clk); #1;
    b_ready_i = 1'b1;
    guard = 0;
    while (bSeen < target && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("b_timeout", 64'd1, 64'd0);
    b_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("write_idle", 64'({b_valid_o, aw_ready_o, w_ready_o}), 64'b010);
  endtask

  task automatic applyRead(input logic [ID_W-1:0] id, input logic [7:0] len, input logic sec, input logic toggle);
    int     guard;
    int     target;
    r_exp_t e;
    @(posedge clk); #1;
    ar_valid_i = 1'b1; ar_id_i = id; ar_len_i = len; ar_sec_err_i = sec;
    guard = 0;
    @(negedge clk);
    while (!ar_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("ar_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id; e.resp = sec ? 2'b10 : 2'b11; e.last = (i == int'(len));
      rq.push_back(e);
    end
    target = rSeen + int'(len) + 1;
    r_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("r_valid_latency", 64'(r_valid_o), 64'd1);
    guard = 0;
    while (guard < 2000) begin
      @(posedge clk); #1;
      if (rSeen >= target) break;
      if (toggle) r_ready_i = ~r_ready_i;
      guard++;
    end
    if (guard >= 2000) checkOutput("r_timeout", 64'd1, 64'd0);
    r_ready_i = 1'b0;
    checkOutput("r_beat_count", 64'(rSeen - (target - int'(len) - 1)), 64'(int'(len) + 1));
    @(negedge clk);
    checkOutput("read_idle", 64'({r_valid_o, r_last_o, ar_ready_o}), 64'b001);
  endtask

  task automatic applyStimulus();
    int start;
    int guard;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 64'({aw_ready_o, ar_ready_o}), 64'b11);
    checkOutput("reset_valids", 64'({w_ready_o, b_valid_o, r_valid_o, r_last_o}), 64'd0);
    checkOutput("reset_fields", 64'({b_id_o, r_id_o, b_resp_o, r_resp_o}), 64'd0);
    checkOutput("reset_rdata", 64'(r_data_o), 64'd0);
`ifdef BUS_MATRIX_ERR_LOG_EN
    checkOutput("reset_log", 64'({err_valid_o, err_is_write_o, err_is_sec_o, err_count_o}), 64'd0);
    checkOutput("reset_log_addr", 64'(err_addr_o), 64'd0);
`endif

    // W beats offered before any AW must not be taken.
    @(posedge clk); #1;
    w_valid_i = 1'b1; w_last_i = 1'b1;
    @(negedge clk);
    checkOutput("w_ready_before_aw", 64'(w_ready_o), 64'd0);
    @(posedge clk); #1;
    w_valid_i = 1'b0; w_last_i = 1'b0;

    applyWrite(4'd3, 1'b0, 4, 0);
    applyWrite(4'd12, 1'b1, 1, 0);
    applyRead(4'd5, 8'd3, 1'b1, 1'b0);
    applyRead(4'd2, 8'd255, 1'b0, 1'b1);

`ifdef BUS_MATRIX_ERR_LOG_EN
    @(posedge clk); #1;
    err_clear_i = 1'b1;
    @(posedge clk); #1;
    err_clear_i = 1'b0;
    @(negedge clk);
    checkOutput("log_cleared_pre", 64'({err_valid_o, err_count_o}), 64'd0);
    aw_addr_i = 32'h4000_0000;
    ar_addr_i = 32'h8000_0000;
`endif
    fork
      applyWrite(4'd7, 1'b1, 2, 5);
      applyRead(4'd9, 8'd7, 1'b0, 1'b0);
    join
`ifdef BUS_MATRIX_ERR_LOG_EN
    checkOutput("log_addr", 64'(err_addr_o), 64'h4000_0000);
    checkOutput("log_flags", 64'({err_valid_o, err_is_write_o, err_is_sec_o}), 64'b111);
    checkOutput("log_count", 64'(err_count_o), 64'd2);
    @(posedge clk); #1;
    err_clear_i = 1'b1;
    @(posedge clk); #1;
    err_clear_i = 1'b0;
    @(negedge clk);
    checkOutput("log_cleared", 64'({err_valid_o, err_is_write_o, err_is_sec_o, err_count_o}), 64'd0);
    checkOutput("log_cleared_addr", 64'(err_addr_o), 64'd0);
`endif

    // Reset after two of eight read beats; the remaining beats are dropped.
    @(posedge clk); #1;
    ar_valid_i = 1'b1; ar_id_i = 4'd6; ar_len_i = 8'd7; ar_sec_err_i = 1'b0;
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) rq.push_back('{id: 4'd6, resp: 2'b11, last: (i == 7)});
    start = rSeen;
    r_ready_i = 1'b1;
    guard = 0;
    while (rSeen < start + 2 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("rst_burst_timeout", 64'd1, 64'd0);
    rst_i = 1'b1; r_ready_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    rq.delete();
    @(negedge clk);
    checkOutput("midrst_r", 64'({r_valid_o, r_last_o, ar_ready_o, aw_ready_o}), 64'b0011);
    checkOutput("midrst_fields", 64'({r_id_o, r_resp_o}), 64'd0);
    applyRead(4'd6, 8'd7, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    checkOutput("b_queue_empty", 64'(bq.size()), 64'd0);
    checkOutput("r_queue_empty", 64'(rq.size()), 64'd0);
  endtask

  initial begin
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
